// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, defaults and stage-control bundle for the stall controller
package pipe_ctrl_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int MDU_TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_bubble;
    logic exmem_we;
    logic exmem_bubble;
    logic memwb_bubble;
  } ctrl_t;
  localparam ctrl_t CTRL_HOLD  = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_RUN   = ctrl_t'(8'b1101_0100);
  localparam ctrl_t CTRL_RESET = ctrl_t'(8'b0010_1011);
  function automatic ctrl_t ctrl_advance(input logic flush);
    ctrl_t c;
    c = CTRL_RUN;
    c.ifid_flush = flush;
    return c;
  endfunction
endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: saturating up-counter with enable and synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = (en && !(&q_q)) ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk) q_q <= clr ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: arbitrates MEM wait, MDU occupancy, load-use and redirect into stage enables/flushes
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken_D,
  input  logic             ex_mdu_op,
  input  logic             mdu_done,
  output logic             mdu_start,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             IF_IDFlush,
  output logic             ID_EXWrite,
  output logic             ID_EXBubble,
  output logic             EX_MEMWrite,
  output logic             EX_MEMBubble,
  output logic             MEM_WBBubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mdu_timeout
);
  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  state_t state_q, state_d, ret_q, ret_d;
  logic pend_q, pend_d, tmo_q, tmo_d;
  logic mem_wait, mdu_ctx, release_mdu, redirect, wd_en;
  logic [WD_W-1:0] wd;
  ctrl_t ctrl;
  always_comb begin
    mem_wait    = mem_req_M & ~mem_ready_M;
    mdu_ctx     = (state_q == MDU_BUSY) || (state_q == MEM_WAIT && ret_q == MDU_BUSY);
    release_mdu = (state_q == MDU_BUSY) && !mem_wait && (mdu_done || pend_q);
    redirect    = !rst && !mem_wait && branch_taken_D &&
                  (release_mdu || (state_q == RUN && !ex_mdu_op && !load_use_stall));
    wd_en       = !rst && (state_q == MDU_BUSY) && !mem_wait && !release_mdu;
    ctrl        = CTRL_HOLD;
    mdu_start   = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    pend_d      = pend_q | (mdu_done & mdu_ctx & (mem_wait | (state_q == MEM_WAIT)));
    tmo_d       = tmo_q | (wd_en && wd == WD_W'(MDU_TIMEOUT - 1));
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (mem_wait) begin
      ctrl.memwb_bubble = 1'b1;
      state_d = MEM_WAIT;
      ret_d = (state_q == MEM_WAIT) ? ret_q : state_q;
    end else if (state_q == MEM_WAIT) begin
      state_d = ret_q;
    end else if (state_q == MDU_BUSY) begin
      ctrl = release_mdu ? ctrl_advance(branch_taken_D) : CTRL_HOLD;
      ctrl.exmem_bubble = !release_mdu;
      pend_d = release_mdu ? 1'b0 : pend_d;
      state_d = release_mdu ? RUN : MDU_BUSY;
    end else if (ex_mdu_op) begin
      mdu_start = 1'b1;
      ctrl.exmem_bubble = 1'b1;
      state_d = MDU_BUSY;
    end else if (load_use_stall) begin
      ctrl = CTRL_RUN;
      ctrl.pc_we = 1'b0;
      ctrl.ifid_we = 1'b0;
      ctrl.idex_bubble = 1'b1;
    end else begin
      ctrl = ctrl_advance(branch_taken_D);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .clr(rst), .en(!rst && !ctrl.pc_we), .q(stall_cycles));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .clr(rst), .en(redirect), .q(flush_count));
  sat_counter #(.W(WD_W)) u_wdog (.clk(clk), .clr(rst || mdu_start), .en(wd_en), .q(wd));
  assign PCWrite      = ctrl.pc_we;
  assign IF_IDWrite   = ctrl.ifid_we;
  assign IF_IDFlush   = ctrl.ifid_flush;
  assign ID_EXWrite   = ctrl.idex_we;
  assign ID_EXBubble  = ctrl.idex_bubble;
  assign EX_MEMWrite  = ctrl.exmem_we;
  assign EX_MEMBubble = ctrl.exmem_bubble;
  assign MEM_WBBubble = ctrl.memwb_bubble;
  assign mdu_timeout  = tmo_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed self-checking bench for the stall controller
module tb_pipeline_stall_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic load_use_stall = 1'b0, branch_taken_D = 1'b0, ex_mdu_op = 1'b0, mdu_done = 1'b0;
  logic mem_req_M = 1'b0, mem_ready_M = 1'b0;
  logic mdu_start, PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble;
  logic EX_MEMWrite, EX_MEMBubble, MEM_WBBubble, mdu_timeout;
  logic [31:0] stall_cycles, flush_count;
  int checks = 0, errors = 0;
  localparam logic [8:0] V_RESET = 9'b0_0010_1011;
  localparam logic [8:0] V_IDLE  = 9'b0_1101_0100;
  localparam logic [8:0] V_FLUSH = 9'b0_1111_0100;
  localparam logic [8:0] V_LU    = 9'b0_0001_1100;
  localparam logic [8:0] V_START = 9'b1_0000_0010;
  localparam logic [8:0] V_BUSY  = 9'b0_0000_0010;
  localparam logic [8:0] V_MWAIT = 9'b0_0000_0001;
  localparam logic [8:0] V_MEXIT = 9'b0_0000_0000;
  pipeline_stall_controller #(.CNT_W(32), .MDU_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .load_use_stall(load_use_stall), .branch_taken_D(branch_taken_D),
    .ex_mdu_op(ex_mdu_op), .mdu_done(mdu_done), .mdu_start(mdu_start),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M), .PCWrite(PCWrite),
    .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush), .ID_EXWrite(ID_EXWrite),
    .ID_EXBubble(ID_EXBubble), .EX_MEMWrite(EX_MEMWrite), .EX_MEMBubble(EX_MEMBubble),
    .MEM_WBBubble(MEM_WBBubble), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .mdu_timeout(mdu_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_ctrl(input string tag, input logic [8:0] exp);
    #2;
    chk(tag, {23'd0, mdu_start, PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble,
              EX_MEMWrite, EX_MEMBubble, MEM_WBBubble}, {23'd0, exp});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    chk_ctrl("reset_outputs", V_RESET);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_stall", stall_cycles, 0);
    chk("reset_flush", flush_count, 0);
    chk("reset_tmo", {31'd0, mdu_timeout}, 0);
    chk_ctrl("idle", V_IDLE);
    tick();
    load_use_stall = 1'b1;
    chk_ctrl("load_use", V_LU);
    tick();
    load_use_stall = 1'b0;
    chk_ctrl("after_lu_idle", V_IDLE);
    chk("lu_stall_cnt", stall_cycles, 1);
    load_use_stall = 1'b1;
    branch_taken_D = 1'b1;
    chk_ctrl("lu_masks_branch", V_LU);
    tick();
    load_use_stall = 1'b0;
    chk_ctrl("branch_flush", V_FLUSH);
    tick();
    branch_taken_D = 1'b0;
    chk("flush_cnt_1", flush_count, 1);
    chk("stall_cnt_2", stall_cycles, 2);
    ex_mdu_op = 1'b1;
    chk_ctrl("mdu_start", V_START);
    tick();
    ex_mdu_op = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_ctrl("mdu_busy", V_BUSY);
      tick();
    end
    mdu_done = 1'b1;
    chk_ctrl("mdu_release", V_IDLE);
    tick();
    mdu_done = 1'b0;
    chk("mdu_stall_cnt", stall_cycles, 8);
    chk_ctrl("mdu_back_run", V_IDLE);
    ex_mdu_op = 1'b1;
    chk_ctrl("mdu2_start", V_START);
    tick();
    ex_mdu_op = 1'b0;
    chk_ctrl("mdu2_busy", V_BUSY);
    tick();
    mdu_done = 1'b1;
    mem_req_M = 1'b1;
    chk_ctrl("mw_enter_done", V_MWAIT);
    tick();
    mdu_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_ctrl("mw_hold", V_MWAIT);
      tick();
    end
    mem_ready_M = 1'b1;
    chk_ctrl("mw_exit", V_MEXIT);
    tick();
    mem_req_M = 1'b0;
    mem_ready_M = 1'b0;
    chk_ctrl("pend_release", V_IDLE);
    tick();
    chk_ctrl("pend_back_run", V_IDLE);
    chk("mw_stall_cnt", stall_cycles, 14);
    chk("no_tmo_yet", {31'd0, mdu_timeout}, 0);
    ex_mdu_op = 1'b1;
    tick();
    ex_mdu_op = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_before", {31'd0, mdu_timeout}, 0);
    tick();
    chk("tmo_set", {31'd0, mdu_timeout}, 1);
    tick();
    tick();
    chk("tmo_sticky", {31'd0, mdu_timeout}, 1);
    chk_ctrl("tmo_still_busy", V_BUSY);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tmo_cleared", {31'd0, mdu_timeout}, 0);
    chk("rst_stall_clr", stall_cycles, 0);
    chk("rst_flush_clr", flush_count, 0);
    ex_mdu_op = 1'b1;
    tick();
    ex_mdu_op = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk_ctrl("rst_mid_mdu", V_RESET);
    tick();
    rst = 1'b0;
    mdu_done = 1'b1;
    chk_ctrl("stale_done_ignored", V_IDLE);
    tick();
    mdu_done = 1'b0;
    ex_mdu_op = 1'b1;
    chk_ctrl("run_after_rst", V_START);
    tick();
    ex_mdu_op = 1'b0;
    chk_ctrl("busy_after_rst", V_BUSY);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
